// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the completer FSM state encoding.
package apb_pkg;

    localparam int APB_ADDR_W = 9;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_slv_mem.sv
// DEPTH x 8 storage: synchronous write, synchronous clear on reset, combinational read.
module apb_slv_mem
    import apb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a byte memory with WAIT_CYCLES wait states per transfer.
// Build option: define APB_SLV_ERR_EN to drive PSLVERR on out-of-range accesses.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_t            state, state_nx;
    logic [3:0]            cnt;
    logic [7:0]            idx_q;
    logic                  wr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic                  capture, cnt_inc, load_rd;
    logic [7:0]            cur_idx;
    logic                  cur_err;
    logic                  mem_we;
    logic [APB_DATA_W-1:0] mem_rdata;
    logic                  unused_paddr;

    assign unused_paddr = PADDR[8];

    // In IDLE the zero-wait path reads before the capture registers are loaded.
    assign cur_idx = (state == IDLE) ? PADDR[7:0] : idx_q;
    assign cur_err = ({24'b0, cur_idx} >= 32'(DEPTH));

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        cnt_inc  = 1'b0;
        load_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        load_rd  = !PWRITE;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_nx = IDLE;
                end else if (PENABLE) begin
                    cnt_inc = 1'b1;
                    if (cnt + 4'd1 == 4'(WAIT_CYCLES)) begin
                        state_nx = RESP;
                        load_rd  = !wr_q;
                    end
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            PRDATA  <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                idx_q   <= PADDR[7:0];
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                cnt     <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 4'd1;
            end
            if (load_rd) begin
                PRDATA <= cur_err ? '0 : mem_rdata;
            end
        end
    end

    assign mem_we = (state == RESP) && PSEL && PENABLE && wr_q && !cur_err;

    apb_slv_mem #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .waddr (idx_q[MEM_AW-1:0]),
        .wdata (wdata_q),
        .raddr (cur_idx[MEM_AW-1:0]),
        .rdata (mem_rdata)
    );

    assign PREADY = (state == RESP);

`ifdef APB_SLV_ERR_EN
    assign PSLVERR = (state == RESP) && cur_err;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized bench: four completers with WAIT_CYCLES 0..3 checked against a byte-array model.
module tb_apb_slave_mem;

  localparam int DEPTH = 64;
  localparam int ND    = 4;
`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  logic [ND-1:0] psel = '0, penable = '0, pwrite = '0;
  logic [ND-1:0] pready, pslverr;
  logic [8:0]    paddr  [ND];
  logic [7:0]    pwdata [ND];
  logic [7:0]    prdata [ND];

  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_wc0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) u_wc1 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_wc2 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
  apb_slave_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_wc3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[3]), .PENABLE(penable[3]), .PWRITE(pwrite[3]),
    .PADDR(paddr[3]), .PWDATA(pwdata[3]), .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  // scoreboard
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_mem [ND][256];
  logic [7:0] last_rd [ND];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      last_rd[d] = 8'h00;
      for (int a = 0; a < 256; a++) exp_mem[d][a] = 8'h00;
    end
    exp_q.delete();
  endtask

  // driver: called just after a rising edge, returns just after the completing edge
  task automatic apb_xfer(input int d, input bit wr, input logic [8:0] addr, input logic [7:0] wd);
    int         idx;
    bit         err;
    int         n;
    bit         done;
    logic [7:0] exp;
    idx  = int'(addr[7:0]);
    err  = (idx >= DEPTH);
    n    = 0;
    done = 1'b0;
    if (!wr) exp_q.push_back(err ? 8'h00 : exp_mem[d][idx]);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    while (!done && n < 40) begin
      @(negedge pclk);
      n++;
      if (pready[d]) begin
        done = 1'b1;
        check("pslverr", pslverr[d], ERR_EN & err);
        if (wr) begin
          check("rd_hold", prdata[d], last_rd[d]);
        end else begin
          exp = exp_q.pop_front();
          check("rdata", prdata[d], exp);
          last_rd[d] = exp;
        end
      end
      @(posedge pclk); #1;
      if (!done) begin
        paddr[d]  = 9'($urandom);
        pwdata[d] = 8'($urandom);
        pwrite[d] = 1'($urandom);
      end
    end
    check("access_cycles", n, d + 1);
    if (wr && !err) exp_mem[d][idx] = wd;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic abort_xfer(input int d, input logic [8:0] addr, input logic [7:0] wd, input int k);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    repeat (k) begin
      @(negedge pclk);
      check("abort_ready", pready[d], 1'b0);
      @(posedge pclk); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge pclk); #1;
    @(negedge pclk);
    check("abort_idle", pready[d], 1'b0);
    check("abort_rdata", prdata[d], last_rd[d]);
    @(posedge pclk); #1;
  endtask

  task automatic reset_mid_write(input int d, input logic [8:0] addr, input logic [7:0] wd);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = addr; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    model_reset();
    @(negedge pclk);
    check("rst_mid_ready", pready[d], 1'b0);
    check("rst_mid_rdata", prdata[d], 8'h00);
    @(posedge pclk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, elapsed %0t required < 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [8:0] a;
    logic [7:0] v;
    for (int d = 0; d < ND; d++) begin
      paddr[d] = '0; pwdata[d] = '0;
    end
    model_reset();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    for (int d = 0; d < ND; d++) begin
      check("reset_ready", pready[d], 1'b0);
      check("reset_err", pslverr[d], 1'b0);
      check("reset_rdata", prdata[d], 8'h00);
    end
    @(posedge pclk); #1;

    // directed boundary cases
    apb_xfer(0, 1'b1, 9'h005, 8'hA5);
    apb_xfer(0, 1'b0, 9'h005, 8'h00);
    check("wc0_readback", prdata[0], 8'hA5);
    apb_xfer(3, 1'b0, 9'h010, 8'h00);
    apb_xfer(1, 1'b1, 9'h040, 8'h3C);
    apb_xfer(1, 1'b0, 9'h040, 8'h00);
    abort_xfer(2, 9'h003, 8'h77, 1);
    apb_xfer(2, 1'b0, 9'h003, 8'h00);
    apb_xfer(1, 1'b1, 9'h102, 8'h11);
    apb_xfer(1, 1'b0, 9'h002, 8'h00);
    check("alias_readback", prdata[1], 8'h11);

    // PENABLE without a setup phase must not start a transfer
    psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 9'h002; pwdata[1] = 8'hEE;
    repeat (3) begin
      @(negedge pclk);
      check("no_setup_ready", pready[1], 1'b0);
      @(posedge pclk); #1;
    end
    psel[1] = 1'b0; penable[1] = 1'b0;
    apb_xfer(1, 1'b0, 9'h002, 8'h00);

    reset_mid_write(3, 9'h001, 8'hFF);
    apb_xfer(3, 1'b0, 9'h001, 8'h00);

    // randomized traffic, mostly in a small window so reads hit written data
    for (int d = 0; d < ND; d++) begin
      for (int t = 0; t < 40; t++) begin
        a[8]   = 1'($urandom_range(0, 1));
        a[7:0] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(DEPTH, 255))
                                             : 8'($urandom_range(0, 15));
        v = 8'($urandom);
        apb_xfer(d, 1'($urandom_range(0, 1)), a, v);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge pclk); #1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 64, number of 8-bit storage locations (1..256).
REQ-002 Parameter WAIT_CYCLES, default 1, wait states inserted per transfer (0..15).
REQ-003 PCLK  input  1  bus clock; single clock, all state on rising edge.
REQ-004 PRESET  input  1  reset, synchronous, active-high.
REQ-005 PSEL  input  1  completer select from the APB requester.
REQ-006 PENABLE  input  1  access-phase indicator.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  9  bus address; bit 8 is requester-side decode and ignored here; PADDR[7:0] is the local index.
REQ-009 PWDATA  input  8  write data.
REQ-010 PRDATA  output  8  read data, registered.
REQ-011 PREADY  output  1  transfer-complete indicator.
REQ-012 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; PREADY = (state==RESP).
REQ-014 IDLE: on edge with PSEL=1, PENABLE=0 (setup), capture PADDR[7:0], PWRITE and PWDATA; clear wait counter; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT: while PSEL=1 and PENABLE=1, counter increments each edge; on reaching WAIT_CYCLES go to RESP; PREADY=1 in access cycle WAIT_CYCLES+1.
REQ-016 WAIT: PSEL=0 on any edge aborts the transfer -> IDLE, no memory update, PRDATA unchanged.
REQ-017 Address error: captured index >= DEPTH.
REQ-018 Read: PRDATA loads mem[index] (or 8'h00 on address error) on the edge entering RESP; PRDATA holds otherwise.
REQ-019 Write: mem[index] <= captured PWDATA on the RESP edge when PSEL&PENABLE; no update on address error.
REQ-020 RESP always returns to IDLE on the next edge; back-to-back transfers (setup immediately after RESP) are accepted without a lost cycle.
REQ-021 Read of an index written in the preceding transfer returns the new value.
REQ-022 Captured address/data/direction are used; PADDR/PWDATA changes during WAIT are ignored.
REQ-023 PENABLE=1 seen in IDLE (protocol violation) is ignored; state stays IDLE.

Reset
REQ-024 PRESET=1 at an edge: state=IDLE, counter=0, PRDATA=8'h00, PREADY=0, PSLVERR=0, all memory locations=8'h00.
REQ-025 Reset mid-transfer (WAIT or RESP) discards the transfer; no memory write occurs on that edge.

Configuration
REQ-026 Macro APB_SLV_ERR_EN defined: PSLVERR = (state==RESP) & address error.
REQ-027 APB_SLV_ERR_EN undefined: PSLVERR tied 0; out-of-range writes silently dropped and reads return 8'h00; timing identical.

Structure
REQ-028 Shared package apb_pkg: state enum (IDLE/WAIT/RESP), APB_ADDR_W=9, APB_DATA_W=8 constants.
REQ-029 Sub-module apb_slv_mem: DEPTH x 8 storage with synchronous write, reset clear, and read port; FSM and counter stay in apb_slave_mem.

Verification
REQ-030 WAIT_CYCLES=0: write 8'hA5 to 9'h005, then read 9'h005 -> PREADY=1 in first access cycle of each transfer, PRDATA=8'hA5, PSLVERR=0.
REQ-031 WAIT_CYCLES=3: read 9'h010 after reset -> PREADY low for 3 access cycles, high on the 4th, PRDATA=8'h00.
REQ-032 DEPTH=64, APB_SLV_ERR_EN defined: write 8'h3C to 9'h040 -> PSLVERR=1 with PREADY; subsequent read of 9'h040 -> PRDATA=8'h00, PSLVERR=1; without the macro, PSLVERR=0 in both transfers.
REQ-033 WAIT_CYCLES=2: write 8'h77 to 9'h003, PSEL dropped after first wait cycle -> FSM returns to IDLE; read 9'h003 -> PRDATA=8'h00.
REQ-034 Write 8'h11 to 9'h102 (bit 8 set) then read 9'h002 -> PRDATA=8'h11.
REQ-035 PRESET asserted in WAIT of a write of 8'hFF to 9'h001 -> PREADY=0 next cycle, subsequent read of 9'h001 returns 8'h00.
